// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter.
// Opcode codes, flag bit positions and FSM state encoding.
package alu_arbiter_pkg;

  localparam int OP_W  = 4;
  localparam int FLG_W = 5;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_AND = 4'h3;
  localparam logic [OP_W-1:0] OP_OR  = 4'h4;
  localparam logic [OP_W-1:0] OP_NOT = 4'h5;

  localparam int FLG_OV = 4;
  localparam int FLG_UN = 3;
  localparam int FLG_AB = 2;
  localparam int FLG_BB = 1;
  localparam int FLG_EQ = 0;

  function automatic logic op_legal(
    input logic [OP_W-1:0] op
  );
    return op inside {OP_NOP, OP_ADD, OP_SUB,
                      OP_AND, OP_OR, OP_NOT};
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin grant: first set request
// at or after the pointer, wrapping to index 0.
module alu_arbiter_rr #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters: arbitrate,
// drive the ALU, wait ALU_LAT edges, return the result.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [FLG_W-1:0]          rsp_flags,
  output logic                      rsp_err,
  output logic [OP_W-1:0]           alu_instr,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_c,
  input  logic [FLG_W-1:0]          alu_flags,
  output logic                      busy,
  output logic [15:0]               ops_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  arb_state_e          r_state;
  arb_state_e          w_next;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_id;
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [CW-1:0]       r_cnt;
  logic                r_drv;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_data;
  logic [FLG_W-1:0]    r_flags;
  logic                r_err;
  logic [OP_W-1:0]     r_alu_instr;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [15:0]         r_ops;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [PW-1:0]       w_gid;
  logic                w_acc;
  logic                w_done;
  logic                w_ack;

  alu_arbiter_rr #(.N(NUM_REQ), .PW(PW)) u_rr (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_gid = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (w_gnt[k]) w_gid = PW'(k);
  end

  assign w_acc  = (r_state == ARB_IDLE) && (|w_gnt);
  assign w_done = (r_state == ARB_EXEC) && !r_drv
                  && (r_cnt == '0);
  assign w_ack  = (r_state == ARB_RESP) && rsp_ready[r_id];

  always_ff @(posedge clk) begin
    if (reset) r_state <= ARB_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ARB_IDLE: if (w_acc)  w_next = ARB_EXEC;
      ARB_EXEC: if (w_done) w_next = ARB_RESP;
      ARB_RESP: if (w_ack)  w_next = ARB_IDLE;
      default:              w_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == ARB_IDLE) ? w_gnt : '0;
    busy      = (r_state != ARB_IDLE);
  end

  // First EXEC cycle drives the ALU; ALU_LAT edges later we capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_op        <= OP_NOP;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_drv       <= 1'b0;
      r_rsp_valid <= '0;
      r_data      <= '0;
      r_flags     <= '0;
      r_err       <= 1'b0;
      r_alu_instr <= OP_NOP;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_ops       <= '0;
    end else begin
      if (w_acc) begin
        r_id  <= w_gid;
        r_op  <= req_op[int'(w_gid)*OP_W +: OP_W];
        r_a   <= req_a[int'(w_gid)*DATA_W +: DATA_W];
        r_b   <= req_b[int'(w_gid)*DATA_W +: DATA_W];
        r_cnt <= CW'(ALU_LAT - 1);
        r_drv <= 1'b1;
      end
      if (r_state == ARB_EXEC) begin
        if (r_drv) begin
          r_drv       <= 1'b0;
          r_alu_instr <= op_legal(r_op) ? r_op : OP_NOP;
          r_alu_a     <= r_a;
          r_alu_b     <= r_b;
        end else if (r_cnt == '0) begin
          r_alu_instr <= OP_NOP;
          r_rsp_valid <= NUM_REQ'(1) << r_id;
          r_err       <= !op_legal(r_op);
          r_data      <= op_legal(r_op) ? alu_c : '0;
          r_flags     <= op_legal(r_op) ? alu_flags : '0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
      if (w_ack) begin
        r_rsp_valid <= '0;
        r_ptr       <= (int'(r_id) == NUM_REQ - 1)
                       ? '0 : r_id + 1'b1;
        r_ops       <= r_ops + 16'd1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_data;
  assign rsp_flags = r_flags;
  assign rsp_err   = r_err;
  assign alu_instr = r_alu_instr;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign ops_done  = r_ops;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stable
    a_req_stable: assert property (
      @(posedge clk) disable iff (reset)
      (req_valid[gi] && !req_ready[gi]) |=>
      (!req_valid[gi] ||
       ($stable(req_op[gi*OP_W +: OP_W]) &&
        $stable(req_a[gi*DATA_W +: DATA_W]) &&
        $stable(req_b[gi*DATA_W +: DATA_W]))));
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU model, cycle scoreboard,
// directed scenarios with literal expectations.
module tb_alu_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int LAT = 1;

  localparam logic [3:0] NOP  = 4'h0;
  localparam logic [3:0] ADD  = 4'h1;
  localparam logic [3:0] SUB  = 4'h2;
  localparam logic [3:0] AND_ = 4'h3;
  localparam logic [3:0] OR_  = 4'h4;
  localparam logic [3:0] NOT_ = 4'h5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*4-1:0]  req_op = '0;
  logic [NR*DW-1:0] req_a = '0;
  logic [NR*DW-1:0] req_b = '0;
  logic [NR-1:0]    rsp_valid;
  logic [NR-1:0]    rsp_ready = '1;
  logic [DW-1:0]    rsp_data;
  logic [4:0]       rsp_flags;
  logic             rsp_err;
  logic [3:0]       alu_instr;
  logic [DW-1:0]    alu_a, alu_b, alu_c;
  logic [4:0]       alu_flags;
  logic             busy;
  logic [15:0]      ops_done;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err), .alu_instr(alu_instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_flags(alu_flags), .busy(busy),
    .ops_done(ops_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // ALU behaviour: {C, ov, un, A>B, B>A, A==B}
  function automatic logic [12:0] alu_fn(
    input logic [3:0] op, input logic [7:0] a, b, hc,
    input logic [1:0] hf);
    logic [7:0] c;
    logic ov, un;
    c = hc; ov = hf[1]; un = hf[0];
    case (op)
      ADD:  begin c = a + b; un = 1'b0;
              ov = (a[7] == b[7]) && (c[7] != a[7]); end
      SUB:  begin c = a - b; ov = 1'b0;
              un = (a[7] != b[7]) && (c[7] != a[7]); end
      AND_: begin c = a & b; ov = 1'b0; un = 1'b0; end
      OR_:  begin c = a | b; ov = 1'b0; un = 1'b0; end
      NOT_: begin c = ~a;    ov = 1'b0; un = 1'b0; end
      default: ;
    endcase
    return {c, ov, un, a > b, b > a, a == b};
  endfunction

  function automatic logic legal(input logic [3:0] op);
    return op <= NOT_;
  endfunction

  function automatic int grant(input logic [NR-1:0] v,
                               input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  logic [7:0]  h_c = '0;
  logic [1:0]  h_f = '0;
  logic [12:0] w_alu;
  assign w_alu     = alu_fn(alu_instr, alu_a, alu_b, h_c, h_f);
  assign alu_c     = w_alu[12:5];
  assign alu_flags = w_alu[4:0];
  always @(posedge clk)
    if (alu_instr != NOP) begin
      h_c <= w_alu[12:5];
      h_f <= w_alu[4:3];
    end

  // Scoreboard: 0 idle, 1 waiting, 2 responding
  int          m_st = 0, m_ptr = 0, m_id = 0, m_cnt = 0;
  logic [3:0]  m_op = '0;
  logic [7:0]  m_a = '0, m_b = '0, m_data = '0;
  logic [4:0]  m_flags = '0;
  logic        m_err = 1'b0;
  logic [15:0] m_ops = '0;
  logic [7:0]  mh_c = '0;
  logic [1:0]  mh_f = '0;

  always @(posedge clk) begin : model
    int g;
    logic [12:0] r;
    cyc <= cyc + 1;
    if (reset) begin
      m_st <= 0; m_ptr <= 0; m_data <= '0;
      m_flags <= '0; m_err <= 1'b0; m_ops <= '0;
    end else begin
      case (m_st)
        0: begin
          g = grant(req_valid, m_ptr);
          if (g >= 0) begin
            m_id  <= g;
            m_op  <= req_op[g*4 +: 4];
            m_a   <= req_a[g*DW +: DW];
            m_b   <= req_b[g*DW +: DW];
            m_cnt <= LAT + 1;
            m_st  <= 1;
          end
        end
        1: begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) begin
            m_st <= 2;
            if (legal(m_op)) begin
              r = alu_fn(m_op, m_a, m_b, mh_c, mh_f);
              m_data  <= r[12:5];
              m_flags <= r[4:0];
              m_err   <= 1'b0;
              if (m_op != NOP) begin
                mh_c <= r[12:5];
                mh_f <= r[4:3];
              end
            end else begin
              m_data <= '0; m_flags <= '0; m_err <= 1'b1;
            end
          end
        end
        default:
          if (rsp_ready[m_id]) begin
            m_st  <= 0;
            m_ptr <= (m_id + 1) % NR;
            m_ops <= m_ops + 16'd1;
          end
      endcase
    end
  end

  always @(negedge clk) begin : compare
    int g;
    logic drv;
    if (chk_en) begin
      g = grant(req_valid, m_ptr);
      chk("req_ready", req_ready,
          (m_st == 0 && g >= 0) ? (NR'(1) << g) : '0);
      chk("rsp_valid", rsp_valid,
          (m_st == 2) ? (NR'(1) << m_id) : '0);
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_flags", rsp_flags, m_flags);
      chk("rsp_err", rsp_err, m_err);
      chk("busy", busy, m_st != 0);
      chk("ops_done", ops_done, m_ops);
      drv = (m_st == 1) && (m_cnt >= 1) && (m_cnt <= LAT)
            && legal(m_op);
      chk("alu_instr", alu_instr, drv ? m_op : NOP);
      if (drv) begin
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
      end
    end
  end

  typedef struct {
    int id; logic [7:0] d; logic [4:0] f; logic e; int lat;
  } rsp_t;
  rsp_t rsp_log[$];
  int   acc_log[$];
  logic [NR-1:0] acc_mark = '0, prev_rv = '0;
  int   last_acc = 0, rsp_start = 0, nonnop = 0;

  always @(negedge clk) begin : mon
    int st;
    rsp_t r;
    acc_mark <= reset ? '0 : (req_valid & req_ready);
    if (!reset)
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i]) begin
          acc_log.push_back(i);
          last_acc <= cyc + 1;
        end
    st = (prev_rv == '0) ? cyc : rsp_start;
    if (rsp_valid != '0 && prev_rv == '0) rsp_start <= cyc;
    if (!reset && (rsp_valid & rsp_ready) != '0) begin
      r.id = -1;
      for (int i = 0; i < NR; i++) if (rsp_valid[i]) r.id = i;
      r.d = rsp_data; r.f = rsp_flags; r.e = rsp_err;
      r.lat = st - last_acc;
      rsp_log.push_back(r);
    end
    prev_rv <= rsp_valid;
    if (alu_instr != NOP) nonnop <= nonnop + 1;
  end

  typedef struct {
    int id; logic [3:0] op; logic [7:0] a, b;
  } cmd_t;
  cmd_t cq[$];

  task automatic push(input int id, input logic [3:0] op,
                      input logic [7:0] a, b);
    cmd_t c;
    c.id = id; c.op = op; c.a = a; c.b = b;
    cq.push_back(c);
  endtask

  initial begin : driver
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (acc_mark[i]) req_valid[i] = 1'b0;
        if (!req_valid[i])
          for (int k = 0; k < cq.size(); k++)
            if (cq[k].id == i) begin
              req_op[i*4 +: 4]  = cq[k].op;
              req_a[i*DW +: DW] = cq[k].a;
              req_b[i*DW +: DW] = cq[k].b;
              req_valid[i] = 1'b1;
              cq.delete(k);
              break;
            end
      end
    end
  end

  task automatic wait_rsp(input int n, input string nm);
    int t = 0;
    while (rsp_log.size() < n && t < 300) begin
      @(posedge clk); #1; t++;
    end
    chk(nm, rsp_log.size() >= n, 1);
  endtask

  task automatic wait_acc(input int n, input string nm);
    int t = 0;
    while (acc_log.size() < n && t < 300) begin
      @(posedge clk); #1; t++;
    end
    chk(nm, acc_log.size() >= n, 1);
  endtask

  task automatic chk_rsp(input int k, input int id,
                         input logic [7:0] d,
                         input logic [4:0] f, input logic e);
    if (k < rsp_log.size()) begin
      chk("lit_id", rsp_log[k].id, id);
      chk("lit_data", rsp_log[k].d, d);
      chk("lit_flags", rsp_log[k].f, f);
      chk("lit_err", rsp_log[k].e, e);
    end else begin
      chk("lit_missing", k, rsp_log.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin : main
    int b, a0, n0, t;
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops", ops_done, 0);
    chk("rst_alu_instr", alu_instr, NOP);
    chk("rst_data", rsp_data, 0);
    chk("rst_err", rsp_err, 0);

    push(0, ADD, 8'h05, 8'h03);
    wait_rsp(1, "t1_timeout");
    chk_rsp(0, 0, 8'h08, 5'b00100, 1'b0);
    if (rsp_log.size() > 0) chk("t1_latency", rsp_log[0].lat, 2);

    do_reset();
    b = rsp_log.size(); a0 = acc_log.size();
    push(0, ADD, 8'h01, 8'h01);
    push(1, SUB, 8'h09, 8'h04);
    push(2, AND_, 8'hF0, 8'h3C);
    push(3, OR_, 8'h0F, 8'h30);
    push(0, ADD, 8'h02, 8'h02);
    wait_rsp(b + 5, "t2_timeout");
    for (int k = 0; k < 5; k++)
      if (a0 + k < acc_log.size())
        chk("rr_order", acc_log[a0 + k], k % 4);
    chk_rsp(b,     0, 8'h02, 5'b00001, 1'b0);
    chk_rsp(b + 1, 1, 8'h05, 5'b00100, 1'b0);
    chk_rsp(b + 2, 2, 8'h30, 5'b00100, 1'b0);
    chk_rsp(b + 3, 3, 8'h3F, 5'b00010, 1'b0);
    chk_rsp(b + 4, 0, 8'h04, 5'b00001, 1'b0);

    b = rsp_log.size();
    push(0, ADD, 8'h7F, 8'h01);
    push(0, SUB, 8'h80, 8'h01);
    wait_rsp(b + 2, "t3_timeout");
    chk_rsp(b,     0, 8'h80, 5'b10100, 1'b0);
    chk_rsp(b + 1, 0, 8'h7F, 5'b01100, 1'b0);

    b = rsp_log.size(); n0 = nonnop;
    push(2, 4'hF, 8'h12, 8'h34);
    wait_rsp(b + 1, "t4_timeout");
    chk_rsp(b, 2, 8'h00, 5'b00000, 1'b1);
    chk("illegal_alu_nop", nonnop - n0, 0);
    a0 = acc_log.size(); b = rsp_log.size();
    push(1, ADD, 8'h01, 8'h02);
    push(3, ADD, 8'h03, 8'h04);
    wait_acc(a0 + 1, "t4b_timeout");
    if (a0 < acc_log.size()) chk("ptr_after_illegal", acc_log[a0], 3);
    wait_rsp(b + 2, "t4c_timeout");

    b = rsp_log.size();
    rsp_ready = 4'b1110;
    push(0, AND_, 8'hAA, 8'h0F);
    t = 0;
    while (!rsp_valid[0] && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("t5_rsp_timeout", rsp_valid[0], 1);
    push(1, OR_, 8'h01, 8'h02);
    a0 = acc_log.size();
    repeat (10) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 4'b0001);
      chk("hold_data", rsp_data, 8'h0A);
    end
    @(posedge clk); #1;
    chk("hold_no_accept", acc_log.size(), a0);
    rsp_ready = '1;
    wait_rsp(b + 2, "t5_timeout");
    chk_rsp(b,     0, 8'h0A, 5'b00100, 1'b0);
    chk_rsp(b + 1, 1, 8'h03, 5'b00010, 1'b0);

    a0 = acc_log.size();
    push(2, SUB, 8'h10, 8'h01);
    wait_acc(a0 + 1, "t6_timeout");
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_exec_busy", busy, 0);
    chk("rst_exec_valid", rsp_valid, 0);
    chk("rst_exec_ops", ops_done, 0);
    repeat (4) begin
      @(negedge clk);
      chk("rst_exec_quiet", rsp_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
